// File: rtl/spram_rr_arbiter.sv
// spram_rr_arbiter: two-requester round-robin front end for a single-port RAM with power-up/on-demand clear
module spram_rr_arbiter #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy
);
    typedef enum logic {INIT, RUN} state_t;
    localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
    state_t              state, state_nxt;
    logic [ADDR_WIDTH:0] cnt, cnt_nxt;
    logic                ptr, ptr_nxt;
    assign rdata = ram_q;
    assign busy  = (state == INIT);
    // state, clear counter, priority pointer and one-cycle-delayed read valids
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            ptr     <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ptr     <= ptr_nxt;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end
    // clear sequencing, arbitration and RAM port muxing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_data  = '0;
        if (state == INIT) begin
            ram_we    = 1'b1;
            ram_addr  = cnt[ADDR_WIDTH-1:0];
            ram_data  = INIT_VALUE;
            cnt_nxt   = cnt + (ADDR_WIDTH+1)'(1);
            state_nxt = (cnt == LAST) ? RUN : INIT;
        end else if (init_req) begin
            state_nxt = INIT;
            cnt_nxt   = '0;
        end else begin
            gnt1     = req1 & (~req0 | ptr);
            gnt0     = req0 & ~gnt1;
            ptr_nxt  = (gnt0 | gnt1) ? gnt0 : ptr;
            ram_we   = (gnt0 & we0) | (gnt1 & we1);
            ram_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
            ram_data = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
        end
    end
endmodule

// File: tb/tb_spram_rr_arbiter.sv
// tb_spram_rr_arbiter: directed and random checks of spram_rr_arbiter against a transaction-level model
module tb_spram_rr_arbiter;
    localparam int DW = 8, AW = 6, DEPTH = 64;
    logic clk = 1'b0, rst = 1'b0, init_req = 1'b0;
    logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
    logic [DW-1:0] rdata, ram_data, ram_q;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] raddr_q;
    int n_cmp = 0, n_err = 0;
    bit m_busy, e_rv0, e_rv1;
    int m_cnt, m_ptr;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] e_rd;

    always #5 clk = ~clk;

    spram_rr_arbiter dut (
        .clk(clk), .rst(rst), .init_req(init_req),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q), .busy(busy)
    );

    // single-port RAM with registered address
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_data;
        raddr_q <= ram_addr;
    end
    assign ram_q = ram[raddr_q];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit r0, input bit w0, input int a0, input int d0,
                          input bit r1, input bit w1, input int a1, input int d1, input bit ir);
        req0 = r0; we0 = w0; addr0 = AW'(a0); wdata0 = DW'(d0);
        req1 = r1; we1 = w1; addr1 = AW'(a1); wdata1 = DW'(d1);
        init_req = ir;
    endtask

    task automatic step;
        int pick, ea, ed;
        bit xw, ewe;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        @(negedge clk);
        pick = -1;
        if (!m_busy && !init_req) pick = (req0 && req1) ? m_ptr : (req0 ? 0 : (req1 ? 1 : -1));
        xw  = (pick == 1) ? we1 : we0;
        xa  = (pick == 1) ? addr1 : addr0;
        xd  = (pick == 1) ? wdata1 : wdata0;
        ewe = m_busy ? 1'b1 : (pick >= 0 && xw);
        ea  = m_busy ? m_cnt : (pick >= 0 ? int'(xa) : 0);
        ed  = m_busy ? 0 : (pick >= 0 ? int'(xd) : 0);
        check("busy", 32'(busy), 32'(m_busy));
        check("gnt0", 32'(gnt0), 32'(pick == 0));
        check("gnt1", 32'(gnt1), 32'(pick == 1));
        check("ram_we", 32'(ram_we), 32'(ewe));
        check("ram_addr", 32'(ram_addr), 32'(ea));
        check("ram_data", 32'(ram_data), 32'(ed));
        check("rvalid0", 32'(rvalid0), 32'(e_rv0));
        check("rvalid1", 32'(rvalid1), 32'(e_rv1));
        if (e_rv0 || e_rv1) check("rdata", 32'(rdata), 32'(e_rd));
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        if (m_busy) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) m_busy = 1'b0;
        end else if (init_req) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (pick >= 0) begin
            if (xw) m_mem[xa] = xd;
            else begin
                e_rd = m_mem[xa];
                if (pick == 0) e_rv0 = 1'b1;
                else e_rv1 = 1'b1;
            end
            m_ptr = 1 - pick;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd1);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_data", 32'(ram_data), 32'd0);
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 1'b1; m_cnt = 0; m_ptr = 0; e_rv0 = 1'b0; e_rv1 = 1'b0;
        m_mem[0] = '0;
    endtask

    initial begin
        pulse_rst();
        repeat (DEPTH) step();
        set_in(0, 0, 0, 0, 1, 0, 63, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 1, 5, 8'hA5, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 5, 0, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 5, 0, 1, 0, 9, 0, 0); repeat (4) step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 1, 7, 8'h3C, 1, 0, 7, 0, 1); step();
        set_in(1, 1, 7, 8'h3C, 1, 0, 7, 0, 0); repeat (DEPTH) step();
        set_in(1, 0, 5, 0, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 5, 0, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse_rst();
        repeat (DEPTH + 1) step();
        for (int i = 0; i < 800; i++) begin
            set_in(1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   ($urandom_range(0, 59) == 0));
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
